// File: rtl/banco_pkg.sv
// rtl/banco_pkg.sv - shared types and helpers for the multi-port register bank
//
// Purpose : FSM state encoding, write-counter width and the port slice helper
//           shared by banco_registro_mp and banco_rd_port.
// Contents: state_t / ST_INIT / ST_READY, NWR_W, port_off().

package banco_pkg;

    // Two-state controller. Kept as plain constants so the encoding is
    // fixed and visible in waveforms of older tools.
    typedef logic [0:0] state_t;

    localparam state_t ST_INIT  = 1'b0;
    localparam state_t ST_READY = 1'b1;

    // Width of the saturating accepted-write counter.
    localparam int NWR_W = 16;

    // Bit offset of lane k in a flat bus whose lanes are w bits wide.
    function automatic int port_off(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/banco_rd_port.sv
// rtl/banco_rd_port.sv - one combinational read port of the register bank
//
// Purpose : selects one word of the flattened array and applies the
//           busy blanking, zero-register rule and optional write bypass.
// Ports   :
//   ra        in  AW         read address
//   mem_flat  in  DEPTH*W    array contents, entry e at [e*W +: W]
//   busy      in  1          clear sequence running, forces rd to zero
//   byp_vld   in  1          a write is being accepted this cycle
//   byp_addr  in  AW         address of that write
//   byp_data  in  W          data of that write
//   rd        out W          read data

module banco_rd_port
    import banco_pkg::*;
#(
    parameter int  W        = 32,
    parameter int  DEPTH    = 32,
    parameter int  ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic [AW-1:0]      ra,
    input  logic [DEPTH*W-1:0] mem_flat,
    input  logic               busy,
    input  logic               byp_vld,
    input  logic [AW-1:0]      byp_addr,
    input  logic [W-1:0]       byp_data,
    output logic [W-1:0]       rd
);

    logic [W-1:0] words [DEPTH];
    logic         zero_sel;
    logic         byp_hit;

    for (genvar e = 0; e < DEPTH; e++) begin : g_unpack
        assign words[e] = mem_flat[port_off(e, W) +: W];
    end

    assign zero_sel = (ZERO_REG != 0) && (ra == '0);
    assign byp_hit  = byp_vld && (ra == byp_addr);

    // Priority, lowest to highest: array, bypass, zero register, busy.
    // DEPTH is a power of two so every ra value indexes a real entry.
    always_comb begin
        rd = words[ra];
        if (byp_hit) begin
            rd = byp_data;
        end
        if (zero_sel || busy) begin
            rd = '0;
        end
    end

endmodule

// File: rtl/banco_registro_mp.sv
// rtl/banco_registro_mp.sv - parametrised multi-read-port register file
//
// Purpose : register bank for the CPU datapath with synchronous write,
//           optional hardwired zero register, a hardware clear sequence
//           after reset or on request, and a saturating write counter.
// Option  : define BANCO_BYPASS_EN to forward an accepted write's data to
//           any read port addressing it in the same cycle.
// Ports   :
//   clk    in  1        rising-edge clock
//   rst_n  in  1        asynchronous active-low reset
//   RA     in  NRD*AW   read addresses, port k at [k*AW +: AW]
//   DR     out NRD*W    read data, port k at [k*W +: W]
//   RW     in  1        write enable
//   dir    in  AW       write address
//   di     in  W        write data
//   clr    in  1        request to re-run the clear sequence
//   busy   out 1        clear sequence running
//   nwr    out 16       saturating count of accepted writes since clear

module banco_registro_mp
    import banco_pkg::*;
#(
    parameter int  W        = 32,
    parameter int  DEPTH    = 32,
    parameter int  NRD      = 2,
    parameter int  ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] RA,
    output logic [NRD*W-1:0]  DR,
    input  logic              RW,
    input  logic [AW-1:0]     dir,
    input  logic [W-1:0]      di,
    input  logic              clr,
    output logic              busy,
    output logic [NWR_W-1:0]  nwr
);

    state_t             state_q, state_d;
    logic [AW-1:0]      ptr_q, ptr_d;
    logic [NWR_W-1:0]   nwr_q, nwr_d;

    logic [W-1:0]       mem_q [DEPTH];
    logic [DEPTH*W-1:0] mem_flat;

    logic               zero_hit;
    logic               wr_ok;
    logic               mem_we;
    logic [AW-1:0]      mem_waddr;
    logic [W-1:0]       mem_wdata;
    logic               byp_vld;

    assign busy = (state_q == ST_INIT);
    assign nwr  = nwr_q;

    // A user write is accepted only in READY, never to the zero register,
    // and never in the same cycle as a clear request (clear wins).
    assign zero_hit = (ZERO_REG != 0) && (dir == '0);
    assign wr_ok    = RW && !busy && !clr && !zero_hit;

`ifdef BANCO_BYPASS_EN
    assign byp_vld = wr_ok;
`else
    assign byp_vld = 1'b0;
`endif

    // Controller: INIT walks ptr over every entry, READY serves the datapath.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        nwr_d   = nwr_q;
        case (state_q)
            ST_INIT: begin
                // clr is deliberately not looked at here: a running clear
                // is never restarted.
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = ST_READY;
                    ptr_d   = '0;
                end
            end
            default: begin
                if (clr) begin
                    state_d = ST_INIT;
                    ptr_d   = '0;
                    nwr_d   = '0;
                end else if (wr_ok && (nwr_q != '1)) begin
                    nwr_d = nwr_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            nwr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            nwr_q   <= nwr_d;
        end
    end

    // Single array write port shared by the clear walk and user writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = dir;
        mem_wdata = di;
        if (busy) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wdata = '0;
        end else if (wr_ok) begin
            mem_we = 1'b1;
        end
    end

    // The array has no reset: its contents are defined by the clear walk.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar e = 0; e < DEPTH; e++) begin : g_flat
        assign mem_flat[port_off(e, W) +: W] = mem_q[e];
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        banco_rd_port #(
            .W        (W),
            .DEPTH    (DEPTH),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .ra       (RA[port_off(k, AW) +: AW]),
            .mem_flat (mem_flat),
            .busy     (busy),
            .byp_vld  (byp_vld),
            .byp_addr (dir),
            .byp_data (di),
            .rd       (DR[port_off(k, W) +: W])
        );
    end

endmodule

// File: tb/tb_banco_registro_mp.sv
// tb/tb_banco_registro_mp.sv - self-checking bench for banco_registro_mp

module tb_banco_registro_mp;

`ifdef BANCO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [9:0]  RA;
    logic [63:0] DR;
    logic        RW;
    logic [4:0]  dir;
    logic [31:0] di;
    logic        clr;
    logic        busy;
    logic [15:0] nwr;

    int total;
    int bad;

    banco_registro_mp dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RA    (RA),
        .DR    (DR),
        .RW    (RW),
        .dir   (dir),
        .di    (di),
        .clr   (clr),
        .busy  (busy),
        .nwr   (nwr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    typedef struct {
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        rw;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [15:0] enwr;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Counts clock windows with busy high, checking blanked reads throughout.
    // Optionally writes and pulses clr mid-sequence; both must be ignored.
    task automatic run_init(input bit wr, input int pulse_at, output int n);
        logic [4:0] a;
        n = 0;
        while (n < 100) begin
            a   = n[4:0];
            RA  = {~a, a};
            RW  = wr;
            dir = 5'd3;
            di  = 32'd7;
            clr = (n == pulse_at);
            #1;
            if (!busy) break;
            n++;
            chk("init_dr", DR, 64'h0);
            @(negedge clk);
        end
        RW  = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] last;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        RA    = '0;
        RW    = 1'b0;
        dir   = '0;
        di    = '0;
        clr   = 1'b0;

        vt[0]  = '{5'd5,  5'd0,  1'b1, 5'd5,  32'hDEADBEEF, BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 16'd0};
        vt[1]  = '{5'd5,  5'd5,  1'b0, 5'd0,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 16'd1};
        vt[2]  = '{5'd0,  5'd0,  1'b1, 5'd0,  32'hFFFFFFFF, 32'h0, 32'h0, 16'd1};
        vt[3]  = '{5'd0,  5'd5,  1'b0, 5'd0,  32'h0,        32'h0, 32'hDEADBEEF, 16'd1};
        vt[4]  = '{5'd7,  5'd7,  1'b1, 5'd7,  32'h12345678, BYP ? 32'h12345678 : 32'h0, BYP ? 32'h12345678 : 32'h0, 16'd1};
        vt[5]  = '{5'd7,  5'd7,  1'b0, 5'd0,  32'h0,        32'h12345678, 32'h12345678, 16'd2};
        vt[6]  = '{5'd31, 5'd30, 1'b1, 5'd31, 32'hA5A5A5A5, BYP ? 32'hA5A5A5A5 : 32'h0, 32'h0, 16'd2};
        vt[7]  = '{5'd31, 5'd30, 1'b1, 5'd30, 32'h5A5A5A5A, 32'hA5A5A5A5, BYP ? 32'h5A5A5A5A : 32'h0, 16'd3};
        vt[8]  = '{5'd30, 5'd31, 1'b0, 5'd0,  32'h0,        32'h5A5A5A5A, 32'hA5A5A5A5, 16'd4};
        vt[9]  = '{5'd5,  5'd7,  1'b1, 5'd5,  32'h11111111, BYP ? 32'h11111111 : 32'hDEADBEEF, 32'h12345678, 16'd4};
        vt[10] = '{5'd5,  5'd7,  1'b0, 5'd0,  32'h0,        32'h11111111, 32'h12345678, 16'd5};

        // Reset state
        repeat (3) @(negedge clk);
        RA = {5'd9, 5'd2};
        #1;
        chk("rst_busy", busy, 1);
        chk("rst_nwr", nwr, 0);
        chk("rst_dr", DR, 0);

        // Clear after reset, with a write attempted while busy
        @(negedge clk);
        rst_n = 1'b1;
        run_init(1'b1, -1, n);
        chk("init_len", n, 32);
        chk("init_nwr", nwr, 0);
        for (int a = 0; a < 32; a++) begin
            RA = {5'(31 - a), 5'(a)};
            #1;
            chk("swept_dr0", DR[31:0], 0);
            chk("swept_dr1", DR[63:32], 0);
        end

        // Table of single-cycle read/write vectors in READY
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            RA  = {vt[i].ra1, vt[i].ra0};
            RW  = vt[i].rw;
            dir = vt[i].wa;
            di  = vt[i].wd;
            #1;
            chk("vec_dr0", DR[31:0], vt[i].e0);
            chk("vec_dr1", DR[63:32], vt[i].e1);
            chk("vec_busy", busy, 0);
            chk("vec_nwr", nwr, vt[i].enwr);
        end
        @(negedge clk);
        RW = 1'b0;
        #1;
        chk("tbl_nwr", nwr, 5);

        // clr colliding with a write, plus clr during INIT being ignored
        RA  = {5'd5, 5'd4};
        RW  = 1'b1;
        dir = 5'd4;
        di  = 32'h44;
        @(negedge clk);
        RW  = 1'b0;
        #1;
        chk("pre_clr_r4", DR[31:0], 32'h44);
        chk("pre_clr_nwr", nwr, 6);
        RW  = 1'b1;
        clr = 1'b1;
        di  = 32'd9;
        #1;
        chk("coll_r4", DR[31:0], 32'h44);
        chk("coll_busy", busy, 0);
        @(negedge clk);
        run_init(1'b0, 10, n);
        chk("clr_len", n, 32);
        chk("clr_nwr", nwr, 0);
        RA = {5'd5, 5'd4};
        #1;
        chk("clr_r4", DR[31:0], 0);
        chk("clr_r5", DR[63:32], 0);

        // Counter saturation with 70000 accepted writes to register 1
        RW  = 1'b1;
        dir = 5'd1;
        for (int i = 0; i < 65534; i++) begin
            di = 32'(i);
            @(negedge clk);
        end
        #1;
        chk("nwr_fffe", nwr, 16'hFFFE);
        @(negedge clk);
        #1;
        chk("nwr_ffff", nwr, 16'hFFFF);
        last = 32'h0;
        for (int i = 0; i < 4465; i++) begin
            last = 32'hC000_0000 + 32'(i);
            di   = last;
            @(negedge clk);
        end
        RW = 1'b0;
        RA = {5'd1, 5'd1};
        #1;
        chk("nwr_sat", nwr, 16'hFFFF);
        chk("r1_last0", DR[31:0], last);
        chk("r1_last1", DR[63:32], last);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/banco_registro_mp.md
Name: banco_registro_mp

Overview:
Parametrised, clocked, multi-read-port register file for the single-cycle/pipelined CPU datapath. It is the successor to the current 32x32 register bank.
- Adds configurable width, depth and read-port count.
- Synchronous write and hardwired zero register.
- Post-reset hardware clear sequence with a busy indication.
- Optional write-to-read bypass.
- Sits between decode (register addresses) and the ALU/writeback stage.

Parameters:
- W, 32, data word width in bits (≥8).
- DEPTH, 32, number of registers; power of two, 2..256.
- AW, $clog2(DEPTH), register address width; derived, not overridden.
- NRD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- RA  in  NRD*AW  read addresses; port k = RA[k*AW +: AW].
- DR  out  NRD*W  read data; port k = DR[k*W +: W].
- RW  in  1  write enable.
- dir  in  AW  write address.
- di  in  W  write data.
- clr  in  1  synchronous request to re-run the clear sequence.
- busy  out  1  high while the clear sequence runs.
- nwr  out  16  saturating count of accepted writes since the last clear.

Behaviour:
- Reset (rst_n=0, async):
  - FSM=INIT, clear pointer=0, busy=1, nwr=0.
  - Array contents are not reset directly; the clear sequence zeroes them.
- FSM states:
  - INIT:
    - Each cycle writes 0 to entry ptr, then ptr++.
    - When ptr==DEPTH-1 is written, go to READY next cycle; busy falls in that same transition, so busy is high for exactly DEPTH cycles after reset release.
  - READY:
    - Normal operation.
    - clr=1 sampled on a rising edge → INIT, ptr=0, busy=1, nwr=0.
    - clr is ignored while already in INIT; the sequence does not restart.
- Reads:
  - Combinational from RA; zero latency.
  - DR = 0 for every port while busy=1.
  - With ZERO_REG=1, RA==0 → DR=0 always.
- Writes:
  - Accepted on a rising edge when RW=1, busy=0, and !(ZERO_REG && dir==0).
  - Array updates at that edge; readers see the new value the same cycle only if bypass is enabled, otherwise from the next cycle.
  - Writes with busy=1 are dropped silently and not counted.
- nwr: +1 per accepted write, saturates at 16'hFFFF, cleared by reset or clr.
- Simultaneous clr and RW in READY: the write is dropped; clr wins.
- Multiple read ports may address the same register; all return the same value.
- Out-of-range addresses cannot occur because DEPTH is a power of two.
- Reset mid-INIT restarts the clear from ptr=0.

Optional Feature:
- Macro: BANCO_BYPASS_EN.
- Defined:
  - In READY with an accepted write pending this cycle (RW=1, write allowed), any port with RA==dir returns di combinationally.
  - The zero-register rule still takes precedence.
- Undefined:
  - DR reflects array contents only; the write is visible the cycle after the edge.

Decomposition:
- Package banco_pkg:
  - FSM state typedef (ST_INIT, ST_READY).
  - NWR_W=16 constant.
  - Helper function for port slice offsets.
- One natural sub-module: banco_rd_port (per-port mux + zero/busy/bypass gating), instantiated NRD times via generate.
- The array, FSM and write logic stay in the top module.

Test Plan:
1. Reset release with DEPTH=32: busy=1 for exactly 32 cycles, then 0; all DR=0 during that time; afterwards reading every address returns 0.
2. Write then read, default build: RW=1, dir=5, di=32'hDEADBEEF at edge N, RA0=5. DR0 must be 32'hDEADBEEF from cycle N+1, not during cycle N. With BANCO_BYPASS_EN defined, DR0=32'hDEADBEEF already in cycle N.
3. Zero register: RW=1, dir=0, di=32'hFFFFFFFF; then RA0=RA1=0 → DR0=DR1=0; nwr unchanged.
4. Write while busy: RW=1 with dir=3, di=7 during INIT → after busy falls, reg 3 reads 0 and nwr=0.
5. clr collision: in READY, clr=1 and RW=1 (dir=4, di=9) in the same cycle → busy=1 for 32 cycles, reg 4 reads 0, nwr=0.
6. Two-port aliasing and counter: RA0=RA1=7 after a write of 32'h12345678 → both ports return it. Issue 70000 accepted writes → nwr=16'hFFFF.
